// File: rtl/uart_rx_parity.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_parity
// Description : Oversampling UART receiver for 8 data bits with even parity
//               and one stop bit. Delivers each byte with parity and framing
//               error flags, qualified by a single-cycle valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_parity #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int                TICK_W    = $clog2(CLKS_PER_BIT);
    localparam logic [TICK_W-1:0] TICK_FULL = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Synchroniser flops; both idle high so reset never looks like a start bit.
    logic rx_meta_q;
    logic rx_s_q;

    state_t            state_q,  state_d;
    logic [TICK_W-1:0] tick_q,   tick_d;
    logic [2:0]        bit_q,    bit_d;
    logic              armed_q,  armed_d;
    logic [7:0]        shift_q,  shift_d;
    logic              par_q,    par_d;
    logic [7:0]        data_q,   data_d;
    logic              valid_q,  valid_d;
    logic              perr_q,   perr_d;
    logic              ferr_q,   ferr_d;

    logic              w_tick_full;

    // Two-flop synchroniser for the asynchronous serial line.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // State, counters, shift register and output holding registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= 3'd0;
            armed_q <= 1'b0;
            shift_q <= 8'h00;
            par_q   <= 1'b0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            armed_q <= armed_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign w_tick_full = (tick_q == TICK_FULL);

    // Next-state logic: bit timing, mid-bit sampling and frame completion.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        armed_d = armed_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;

        case (state_q)
            S_IDLE: begin
                // A start edge only counts once the line has been seen high,
                // so a line stuck low (break) cannot launch repeated frames.
                if (armed_q && !rx_s_q) begin
                    state_d = S_START;
                    tick_d  = '0;
                    armed_d = 1'b0;
                end else if (rx_s_q) begin
                    armed_d = 1'b1;
                end
            end

            S_START: begin
                if (tick_q == TICK_HALF) begin
                    tick_d = '0;
                    if (!rx_s_q) begin
                        state_d = S_DATA;
                        bit_d   = 3'd0;
                    end else begin
                        // Low pulse shorter than half a bit: treat as a glitch.
                        state_d = S_IDLE;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end

            S_DATA: begin
                if (w_tick_full) begin
                    tick_d          = '0;
                    shift_d[bit_q]  = rx_s_q;
                    if (bit_q == 3'd7) begin
                        state_d = S_PARITY;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end

            S_PARITY: begin
                if (w_tick_full) begin
                    tick_d  = '0;
                    par_d   = rx_s_q;
                    state_d = S_STOP;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end

            S_STOP: begin
                if (w_tick_full) begin
                    // Results are registered here so they appear, with the
                    // strobe, on the cycle after the stop-bit sample. A high
                    // stop bit re-arms at once so a back-to-back start bit is
                    // accepted on its first low cycle.
                    tick_d  = '0;
                    data_d  = shift_q;
                    perr_d  = ^{shift_q, par_q};
                    ferr_d  = ~rx_s_q;
                    valid_d = 1'b1;
                    armed_d = rx_s_q;
                    state_d = S_IDLE;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                tick_d  = '0;
            end
        endcase
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire
